// File: rtl/flash_arbiter.sv
// Parallel NOR flash read sequencer shared round-robin between port A (Z80 cartridge)
// and port B (secondary reader), with a one-byte last-read cache on port A.
//
// state     | meaning
// ----------|----------------------------------------------------------
// S_IDLE    | CE_N/OE_N high; serve A cache hit or arbitrate and grant
// S_ACCESS  | CE_N/OE_N low; count down the access time, sample fl_dq at 0
// S_RECOVER | CE_N/OE_N high; bus turnaround, requests not evaluated
module flash_arbiter #(
   parameter int ACCESS_CYCLES   = 4,
   parameter int RECOVERY_CYCLES = 1,
   parameter bit CACHE_EN        = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        a_req,
   input  logic [21:0] a_addr,
   output logic [7:0]  a_data,
   output logic        a_ack,
   input  logic        b_req,
   input  logic [21:0] b_addr,
   output logic [7:0]  b_data,
   output logic        b_ack,
   input  logic [7:0]  fl_dq,
   output logic [21:0] FL_ADDR,
   output logic        FL_CE_N,
   output logic        FL_OE_N,
   output logic        FL_WE_N,
   output logic        FL_RST_N
);

   localparam int CW = $clog2(ACCESS_CYCLES);
   localparam int RW = (RECOVERY_CYCLES > 1) ? $clog2(RECOVERY_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT  = CW'(ACCESS_CYCLES - 1);
   localparam logic [RW-1:0] RCNT_INIT = RW'(RECOVERY_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [RW-1:0] rcnt, rcnt_d;
   logic [21:0]   addr_d;
   logic          en_n, en_n_d;
   logic          last_b, last_b_d;
   logic          cache_valid, cache_valid_d;
   logic [21:0]   cache_addr, cache_addr_d;
   logic [7:0]    cache_data, cache_data_d;
   logic [7:0]    a_data_d, b_data_d;
   logic          a_ack_d, b_ack_d;
   logic          cache_hit, pick_b;

   assign cache_hit = CACHE_EN && cache_valid && a_req && (a_addr == cache_addr);
   assign FL_CE_N   = en_n;
   assign FL_OE_N   = en_n;
   assign FL_WE_N   = 1'b1;

   always_comb begin
      state_d       = state;
      cnt_d         = cnt;
      rcnt_d        = rcnt;
      addr_d        = FL_ADDR;
      en_n_d        = en_n;
      last_b_d      = last_b;
      cache_valid_d = cache_valid;
      cache_addr_d  = cache_addr;
      cache_data_d  = cache_data;
      a_data_d      = a_data;
      b_data_d      = b_data;
      a_ack_d       = 1'b0;
      b_ack_d       = 1'b0;
      pick_b        = 1'b0;
      case (state)
         S_IDLE: begin
            if (cache_hit) begin
               a_data_d = cache_data;
               a_ack_d  = 1'b1;
            end else if (a_req || b_req) begin
               // With both requesting, the port not served last wins.
               pick_b   = b_req && (!a_req || !last_b);
               addr_d   = pick_b ? b_addr : a_addr;
               en_n_d   = 1'b0;
               cnt_d    = CNT_INIT;
               last_b_d = pick_b;
               state_d  = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt == '0) begin
               if (last_b) begin
                  b_data_d = fl_dq;
                  b_ack_d  = 1'b1;
               end else begin
                  a_data_d = fl_dq;
                  a_ack_d  = 1'b1;
                  if (CACHE_EN) begin
                     cache_valid_d = 1'b1;
                     cache_addr_d  = FL_ADDR;
                     cache_data_d  = fl_dq;
                  end
               end
               en_n_d  = 1'b1;
               rcnt_d  = RCNT_INIT;
               state_d = S_RECOVER;
            end else begin
               cnt_d = cnt - CW'(1);
            end
         end
         S_RECOVER: begin
            if (rcnt == '0) state_d = S_IDLE;
            else            rcnt_d  = rcnt - RW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         rcnt        <= '0;
         FL_ADDR     <= '0;
         en_n        <= 1'b1;
         last_b      <= 1'b1;
         cache_valid <= 1'b0;
         cache_addr  <= '0;
         cache_data  <= '0;
         a_data      <= '0;
         b_data      <= '0;
         a_ack       <= 1'b0;
         b_ack       <= 1'b0;
         FL_RST_N    <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         rcnt        <= rcnt_d;
         FL_ADDR     <= addr_d;
         en_n        <= en_n_d;
         last_b      <= last_b_d;
         cache_valid <= cache_valid_d;
         cache_addr  <= cache_addr_d;
         cache_data  <= cache_data_d;
         a_data      <= a_data_d;
         b_data      <= b_data_d;
         a_ack       <= a_ack_d;
         b_ack       <= b_ack_d;
         FL_RST_N    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_flash_arbiter.sv
// Bench for flash_arbiter: a flash model drives fl_dq from FL_ADDR, expected acks go
// through a scoreboard queue; a second instance with the cache disabled is compared too.
module tb_flash_arbiter;

   typedef struct {
      logic        a_en;
      logic [21:0] a_addr;
      logic        b_en;
      logic [21:0] b_addr;
   } vec_t;

   typedef struct {
      logic       is_b;
      logic [7:0] data;
   } exp_t;

   logic        clk, reset_n;
   logic        a_req, b_req;
   logic [21:0] a_addr, b_addr;
   logic [7:0]  a_data, b_data, fl_dq, fl_dq_nc;
   logic        a_ack, b_ack;
   logic [21:0] fl_addr;
   logic        fl_ce_n, fl_oe_n, fl_we_n, fl_rst_n;
   logic [7:0]  nc_a_data, nc_b_data;
   logic        nc_a_ack, nc_b_ack;
   logic [21:0] nc_fl_addr;
   logic        nc_ce_n, nc_oe_n, nc_we_n, nc_rst_n;

   logic        force_en;
   logic [7:0]  force_val;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   logic exp_last_b;
   logic exp_cv;
   logic [21:0] exp_ca;

   function automatic logic [7:0] fmodel(input logic [21:0] ad);
      return ad[7:0] ^ ad[15:8] ^ {2'b00, ad[21:16]} ^ 8'h5A;
   endfunction

   assign fl_dq    = force_en ? force_val : fmodel(fl_addr);
   assign fl_dq_nc = force_en ? force_val : fmodel(nc_fl_addr);

   flash_arbiter #(.ACCESS_CYCLES(4), .RECOVERY_CYCLES(1), .CACHE_EN(1'b1)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
      .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
      .fl_dq(fl_dq), .FL_ADDR(fl_addr), .FL_CE_N(fl_ce_n), .FL_OE_N(fl_oe_n),
      .FL_WE_N(fl_we_n), .FL_RST_N(fl_rst_n));

   flash_arbiter #(.ACCESS_CYCLES(4), .RECOVERY_CYCLES(1), .CACHE_EN(1'b0)) dut_nc (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_addr(a_addr), .a_data(nc_a_data), .a_ack(nc_a_ack),
      .b_req(b_req), .b_addr(b_addr), .b_data(nc_b_data), .b_ack(nc_b_ack),
      .fl_dq(fl_dq_nc), .FL_ADDR(nc_fl_addr), .FL_CE_N(nc_ce_n), .FL_OE_N(nc_oe_n),
      .FL_WE_N(nc_we_n), .FL_RST_N(nc_rst_n));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every ack pops the oldest expected completion.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (a_ack || b_ack) begin
            chk("ack_exclusive", {31'b0, a_ack & b_ack}, 32'd0);
            if (sb.size() == 0) begin
               chk("unexpected_ack", {30'b0, a_ack, b_ack}, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("sb_port_b", {31'b0, b_ack}, {31'b0, e.is_b});
               chk("sb_data", {24'b0, b_ack ? b_data : a_data}, {24'b0, e.data});
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired actual=timeout required=finish");
      $fatal(1);
   end

   task automatic push(input logic is_b, input logic [7:0] d);
      exp_t e;
      e.is_b = is_b;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      a_req = 1'b0;
      b_req = 1'b0;
      repeat (3) @(negedge clk);
      sb.delete();
      exp_last_b = 1'b1;
      exp_cv = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic wait_done(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (a_ack) a_req = 1'b0;
         if (b_ack) b_req = 1'b0;
         if (!a_req && !b_req) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         chk({name, "_timeout"}, 32'd1, 32'd0);
         a_req = 1'b0;
         b_req = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk({name, "_sb_drained"}, sb.size(), 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic hit;
      hit = v.a_en && exp_cv && (v.a_addr == exp_ca);
      if (v.a_en && v.b_en) begin
         if (hit || exp_last_b) begin
            push(1'b0, fmodel(v.a_addr));
            push(1'b1, fmodel(v.b_addr));
            exp_last_b = 1'b1;
         end else begin
            push(1'b1, fmodel(v.b_addr));
            push(1'b0, fmodel(v.a_addr));
            exp_last_b = 1'b0;
         end
      end else if (v.a_en) begin
         push(1'b0, fmodel(v.a_addr));
         if (!hit) exp_last_b = 1'b0;
      end else if (v.b_en) begin
         push(1'b1, fmodel(v.b_addr));
         exp_last_b = 1'b1;
      end
      if (v.a_en && !hit) begin
         exp_cv = 1'b1;
         exp_ca = v.a_addr;
      end
      a_addr = v.a_addr;
      b_addr = v.b_addr;
      a_req  = v.a_en;
      b_req  = v.b_en;
      wait_done($sformatf("vec%0d", idx));
   endtask

   vec_t vecs[10];

   initial begin
      int acks;
      bit ce_seen_low;
      bit got;
      reset_n = 1'b1; a_req = 1'b0; b_req = 1'b0;
      a_addr = '0; b_addr = '0; force_en = 1'b0; force_val = '0;
      exp_last_b = 1'b1; exp_cv = 1'b0; exp_ca = '0;

      vecs[0] = '{1'b1, 22'h001000, 1'b0, 22'h000000};
      vecs[1] = '{1'b0, 22'h000000, 1'b1, 22'h002000};
      vecs[2] = '{1'b1, 22'h003000, 1'b1, 22'h004000};
      vecs[3] = '{1'b1, 22'h007000, 1'b0, 22'h000000};
      vecs[4] = '{1'b1, 22'h008000, 1'b1, 22'h009000};
      vecs[5] = '{1'b1, 22'h008000, 1'b0, 22'h000000};
      vecs[6] = '{1'b1, 22'h008000, 1'b1, 22'h00A000};
      vecs[7] = '{1'b1, 22'h3FFFFF, 1'b0, 22'h000000};
      vecs[8] = '{1'b0, 22'h000000, 1'b1, 22'h000000};
      vecs[9] = '{1'b1, 22'h3FFFFE, 1'b1, 22'h3FFFFF};

      // Reset values, then FL_RST_N follows one edge after release.
      @(negedge clk);
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ce_n", {31'b0, fl_ce_n}, 32'd1);
      chk("rst_oe_n", {31'b0, fl_oe_n}, 32'd1);
      chk("rst_we_n", {31'b0, fl_we_n}, 32'd1);
      chk("rst_addr", {10'b0, fl_addr}, 32'd0);
      chk("rst_fl_rst_n", {31'b0, fl_rst_n}, 32'd0);
      chk("rst_acks", {30'b0, a_ack, b_ack}, 32'd0);
      chk("rst_data", {16'b0, a_data, b_data}, 32'd0);
      reset_n = 1'b1;
      chk("rst_fl_rst_n_hold", {31'b0, fl_rst_n}, 32'd0);
      @(negedge clk);
      chk("rst_fl_rst_n_rel", {31'b0, fl_rst_n}, 32'd1);

      // Single A read with fixed flash data.
      force_en = 1'b1; force_val = 8'h5A;
      push(1'b0, 8'h5A);
      a_addr = 22'h000123; a_req = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("rdA_addr_c%0d", k), {10'b0, fl_addr}, 32'h123);
         chk($sformatf("rdA_ce_c%0d", k), {30'b0, fl_ce_n, fl_oe_n}, 32'd0);
         chk($sformatf("rdA_noack_c%0d", k), {31'b0, a_ack}, 32'd0);
      end
      @(negedge clk);
      chk("rdA_ack", {31'b0, a_ack}, 32'd1);
      chk("rdA_data", {24'b0, a_data}, 32'h5A);
      chk("rdA_ce_off", {30'b0, fl_ce_n, fl_oe_n}, 32'd3);
      a_req = 1'b0;
      @(negedge clk);
      chk("rdA_ack_pulse", {31'b0, a_ack}, 32'd0);
      chk("rdA_recover_ce", {31'b0, fl_ce_n}, 32'd1);
      chk("rdA_data_hold", {24'b0, a_data}, 32'h5A);
      force_en = 1'b0;

      // Simultaneous requests from reset: A then B.
      do_reset();
      begin
         vec_t v;
         v = '{1'b1, 22'h000040, 1'b1, 22'h000080};
         run_vec(v, 100);
      end

      // Both held: grants alternate A,B,A,B.
      push(1'b0, fmodel(22'h011000));
      push(1'b1, fmodel(22'h012000));
      push(1'b0, fmodel(22'h011100));
      push(1'b1, fmodel(22'h012000));
      a_addr = 22'h011000; b_addr = 22'h012000;
      a_req = 1'b1; b_req = 1'b1;
      acks = 0;
      for (int i = 0; i < 200 && acks < 4; i++) begin
         @(negedge clk);
         if (a_ack) a_addr = a_addr + 22'h000100;
         if (a_ack || b_ack) acks++;
      end
      a_req = 1'b0; b_req = 1'b0;
      chk("alt_ack_count", acks, 32'd4);
      repeat (3) @(negedge clk);
      chk("alt_sb_drained", sb.size(), 32'd0);
      exp_last_b = 1'b1; exp_cv = 1'b1; exp_ca = 22'h011100;

      // Table-driven vectors from a clean reset.
      do_reset();
      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Reset during ACCESS cycle 2 aborts the read.
      @(negedge clk);
      b_addr = 22'h000055; b_req = 1'b1;
      @(negedge clk);
      chk("abort_ce_low", {31'b0, fl_ce_n}, 32'd0);
      @(negedge clk);
      reset_n = 1'b0; b_req = 1'b0;
      @(negedge clk);
      chk("abort_ce_oe", {30'b0, fl_ce_n, fl_oe_n}, 32'd3);
      reset_n = 1'b1;
      exp_last_b = 1'b1; exp_cv = 1'b0;
      acks = 0;
      ce_seen_low = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (a_ack || b_ack) acks++;
         if (!fl_ce_n) ce_seen_low = 1'b1;
      end
      chk("abort_no_ack", acks, 32'd0);
      chk("abort_idle_ce", {31'b0, ce_seen_low}, 32'd0);

      // Address change after grant is ignored.
      push(1'b1, fmodel(22'h000200));
      b_addr = 22'h000200; b_req = 1'b1;
      @(negedge clk);
      chk("baddr_c1", {10'b0, fl_addr}, 32'h200);
      b_addr = 22'h000300;
      for (int k = 2; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("baddr_c%0d", k), {10'b0, fl_addr}, 32'h200);
      end
      @(negedge clk);
      chk("baddr_ack", {31'b0, b_ack}, 32'd1);
      b_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("baddr_sb_drained", sb.size(), 32'd0);

      // Cache hit vs cache-disabled instance.
      do_reset();
      force_en = 1'b1; force_val = 8'h3C;
      push(1'b0, 8'h3C);
      a_addr = 22'h000010; a_req = 1'b1;
      wait_done("cache_fill");
      force_val = 8'hFF;
      push(1'b0, 8'h3C);
      a_req = 1'b1;
      @(negedge clk);
      chk("cache_ack_1edge", {31'b0, a_ack}, 32'd1);
      chk("cache_data", {24'b0, a_data}, 32'h3C);
      chk("cache_ce_high", {31'b0, fl_ce_n}, 32'd1);
      a_req = 1'b0;
      got = 1'b0;
      ce_seen_low = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (!fl_ce_n) ce_seen_low = 1'b1;
         if (nc_a_ack && !got) begin
            got = 1'b1;
            chk("nocache_data", {24'b0, nc_a_data}, 32'hFF);
         end
      end
      chk("nocache_ack_seen", {31'b0, got}, 32'd1);
      chk("cache_no_flash_cycle", {31'b0, ce_seen_low}, 32'd0);
      force_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
